// File: rtl/bram_copy_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bram_copy_ctrl
//  Function : Copies a block of words inside one true dual-port BRAM.
//             Port 0 reads the source region, port 1 writes the destination
//             region one cycle later. Addresses wrap modulo MEM_SIZE.
//  Revision : 1.0 - initial release
// ============================================================================
module bram_copy_ctrl #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 7,
  parameter int MEM_SIZE = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [AWIDTH-1:0] src_i,
  input  logic [AWIDTH-1:0] dst_i,
  input  logic [AWIDTH:0]   len_i,
  output logic              idle_o,
  output logic              run_o,
  output logic              done_o,
  output logic [AWIDTH-1:0] addr0_o,
  output logic              ce0_o,
  output logic              we0_o,
  input  logic [DWIDTH-1:0] q0_i,
  output logic [AWIDTH-1:0] addr1_o,
  output logic              ce1_o,
  output logic              we1_o,
  output logic [DWIDTH-1:0] d1_o
);

  localparam logic [AWIDTH:0] MEM_LIM = (AWIDTH+1)'(MEM_SIZE);
  localparam logic [AWIDTH:0] CNT_ONE = (AWIDTH+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [AWIDTH-1:0] src;
  logic [AWIDTH-1:0] dst;
  logic [AWIDTH:0]   len;
  logic [AWIDTH:0]   rd_cnt;
  logic [AWIDTH:0]   wr_cnt;
  logic              wr_vld;
  logic              rd_en;
  logic [AWIDTH:0]   len_clamped;

  // base + offset folded back into 0..MEM_SIZE-1; one subtraction suffices
  // because both operands are below MEM_SIZE+1.
  function automatic logic [AWIDTH-1:0] wrap_add(input logic [AWIDTH-1:0] base,
                                                 input logic [AWIDTH:0]   cnt);
    logic [AWIDTH:0] sum;
    sum = {1'b0, base} + cnt;
    if (sum >= MEM_LIM) begin
      sum = sum - MEM_LIM;
    end
    return AWIDTH'(sum);
  endfunction

  assign len_clamped = (len_i > MEM_LIM) ? MEM_LIM : len_i;

  // State register; reset drops straight to IDLE, aborting any copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and read-enable generation.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt = (len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        rd_en = (rd_cnt < len);
        // Leave in the cycle the final write is presented to port 1.
        if (wr_vld && (wr_cnt == len - CNT_ONE)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Config latch, read/write counters and the one-cycle read-latency pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src    <= '0;
      dst    <= '0;
      len    <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      wr_vld <= 1'b0;
    end else begin
      wr_vld <= rd_en;
      case (state)
        IDLE: begin
          if (start_i) begin
            src    <= src_i;
            dst    <= dst_i;
            len    <= len_clamped;
            rd_cnt <= '0;
            wr_cnt <= '0;
          end
        end
        RUN: begin
          if (rd_en) begin
            rd_cnt <= rd_cnt + CNT_ONE;
          end
          if (wr_vld) begin
            wr_cnt <= wr_cnt + CNT_ONE;
          end
        end
        default: begin
          rd_cnt <= '0;
          wr_cnt <= '0;
        end
      endcase
    end
  end

  assign idle_o  = (state == IDLE);
  assign run_o   = (state == RUN);
  assign done_o  = (state == DONE);

  assign ce0_o   = rd_en;
  assign we0_o   = 1'b0;
  assign addr0_o = wrap_add(src, rd_cnt);

  // Write data is the BRAM read data passed straight through; held at zero
  // outside write cycles so the port is quiet when idle.
  assign ce1_o   = wr_vld;
  assign we1_o   = wr_vld;
  assign addr1_o = wrap_add(dst, wr_cnt);
  assign d1_o    = wr_vld ? q0_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_bram_copy_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_bram_copy_ctrl
//  Function : Directed self-checking bench for bram_copy_ctrl with a
//             behavioural dual-port BRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bram_copy_ctrl;

  localparam int DWIDTH   = 32;
  localparam int AWIDTH   = 7;
  localparam int MEM_SIZE = 100;
  localparam int DEPTH    = 1 << AWIDTH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [AWIDTH-1:0] src_i = '0;
  logic [AWIDTH-1:0] dst_i = '0;
  logic [AWIDTH:0]   len_i = '0;
  logic              idle_o, run_o, done_o;
  logic [AWIDTH-1:0] addr0_o, addr1_o;
  logic              ce0_o, we0_o, ce1_o, we1_o;
  logic [DWIDTH-1:0] q0_i;
  logic [DWIDTH-1:0] d1_o;

  logic [DWIDTH-1:0] mem [0:DEPTH-1];
  logic              load_en = 1'b0;
  logic [DWIDTH-1:0] load_base = '0;
  int                rd_count = 0;
  int                wr_count = 0;
  int                done_count = 0;
  logic              bad_addr = 1'b0;

  int checks = 0;
  int errors = 0;

  bram_copy_ctrl #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .src_i(src_i), .dst_i(dst_i), .len_i(len_i),
    .idle_o(idle_o), .run_o(run_o), .done_o(done_o),
    .addr0_o(addr0_o), .ce0_o(ce0_o), .we0_o(we0_o), .q0_i(q0_i),
    .addr1_o(addr1_o), .ce1_o(ce1_o), .we1_o(we1_o), .d1_o(d1_o)
  );

  always #5 clk = ~clk;

  // BRAM model: 1-cycle read on port 0, write on port 1, plus bulk preload.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= load_base + DWIDTH'(i);
    end else begin
      if (ce0_o) begin
        q0_i     <= mem[addr0_o];
        rd_count <= rd_count + 1;
      end
      if (ce1_o && we1_o) begin
        mem[addr1_o] <= d1_o;
        wr_count     <= wr_count + 1;
      end
    end
    if (done_o) done_count <= done_count + 1;
    if ((ce0_o && addr0_o >= AWIDTH'(MEM_SIZE)) || (ce1_o && addr1_o >= AWIDTH'(MEM_SIZE)))
      bad_addr <= 1'b1;
  end

  task automatic preload(input logic [DWIDTH-1:0] base);
    @(negedge clk);
    load_base = base;
    load_en   = 1'b1;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  // Drive start for exactly one sampling edge; returns 1ns after edge 0.
  task automatic start_copy(input int s, input int d, input int l);
    @(negedge clk);
    src_i   = AWIDTH'(s);
    dst_i   = AWIDTH'(d);
    len_i   = (AWIDTH+1)'(l);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (idle_o !== 1'b1 || run_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: idle/run/done=%b%b%b expected 100", idle_o, run_o, done_o);
    end
    checks++;
    if (ce0_o !== 1'b0 || ce1_o !== 1'b0 || we1_o !== 1'b0 || we0_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_enables: ce0/we0/ce1/we1=%b%b%b%b expected 0000", ce0_o, we0_o, ce1_o, we1_o);
    end
    checks++;
    if (addr0_o !== '0 || addr1_o !== '0 || d1_o !== '0) begin
      errors++;
      $display("FAIL reset_buses: addr0=%0d addr1=%0d d1=%h expected 0 0 0", addr0_o, addr1_o, d1_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_copy();
    preload(32'hA0);
    start_copy(0, 50, 10);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      checks++;
      if (ce0_o !== (c <= 10) || (c <= 10 && addr0_o !== AWIDTH'(c - 1))) begin
        errors++;
        $display("FAIL basic_read c=%0d: ce0=%b addr0=%0d expected ce0=%b addr0=%0d", c, ce0_o, addr0_o, c <= 10, c - 1);
      end
      checks++;
      if (ce1_o !== (c >= 2 && c <= 11) || we1_o !== ce1_o ||
          (ce1_o && (addr1_o !== AWIDTH'(50 + c - 2) || d1_o !== DWIDTH'(32'hA0 + c - 2)))) begin
        errors++;
        $display("FAIL basic_write c=%0d: ce1=%b we1=%b addr1=%0d d1=%h expected ce1=%b addr1=%0d d1=%h",
                 c, ce1_o, we1_o, addr1_o, d1_o, c >= 2 && c <= 11, 50 + c - 2, 32'hA0 + c - 2);
      end
      checks++;
      if (run_o !== (c <= 11) || done_o !== (c == 12) || idle_o !== (c == 13)) begin
        errors++;
        $display("FAIL basic_status c=%0d: run/done/idle=%b%b%b expected %b%b%b",
                 c, run_o, done_o, idle_o, c <= 11, c == 12, c == 13);
      end
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (mem[50 + k] !== DWIDTH'(32'hA0 + k)) begin
        errors++;
        $display("FAIL basic_mem[%0d]: got %h expected %h", 50 + k, mem[50 + k], 32'hA0 + k);
      end
    end
    checks++;
    if (mem[60] !== DWIDTH'(32'hA0 + 60)) begin
      errors++;
      $display("FAIL basic_mem_after: mem[60]=%h expected %h", mem[60], 32'hA0 + 60);
    end
  endtask

  task automatic test_zero_length();
    int rd0, wr0;
    rd0 = rd_count;
    wr0 = wr_count;
    start_copy(3, 60, 0);
    @(negedge clk);
    checks++;
    if (done_o !== 1'b1 || run_o !== 1'b0 || ce0_o !== 1'b0 || ce1_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_done: done/run/ce0/ce1=%b%b%b%b expected 1000", done_o, run_o, ce0_o, ce1_o);
    end
    @(negedge clk);
    checks++;
    if (idle_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_idle: idle/done=%b%b expected 10", idle_o, done_o);
    end
    checks++;
    if (rd_count !== rd0 || wr_count !== wr0) begin
      errors++;
      $display("FAIL zero_len_access: reads=%0d writes=%0d expected 0 0", rd_count - rd0, wr_count - wr0);
    end
  endtask

  task automatic test_wrap();
    preload(32'hB000);
    start_copy(95, 20, 8);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c <= 8) begin
        checks++;
        if (ce0_o !== 1'b1 || addr0_o !== AWIDTH'((95 + c - 1) % MEM_SIZE)) begin
          errors++;
          $display("FAIL wrap_read c=%0d: ce0=%b addr0=%0d expected 1 %0d", c, ce0_o, addr0_o, (95 + c - 1) % MEM_SIZE);
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mem[20 + k] !== DWIDTH'(32'hB000 + (95 + k) % MEM_SIZE)) begin
        errors++;
        $display("FAIL wrap_src_mem[%0d]: got %h expected %h", 20 + k, mem[20 + k], 32'hB000 + (95 + k) % MEM_SIZE);
      end
    end
    start_copy(10, 97, 5);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 6) begin
        checks++;
        if (ce1_o !== 1'b1 || addr1_o !== AWIDTH'((97 + c - 2) % MEM_SIZE)) begin
          errors++;
          $display("FAIL wrap_write c=%0d: ce1=%b addr1=%0d expected 1 %0d", c, ce1_o, addr1_o, (97 + c - 2) % MEM_SIZE);
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (mem[(97 + k) % MEM_SIZE] !== DWIDTH'(32'hB000 + 10 + k)) begin
        errors++;
        $display("FAIL wrap_dst_mem[%0d]: got %h expected %h", (97 + k) % MEM_SIZE, mem[(97 + k) % MEM_SIZE], 32'hB000 + 10 + k);
      end
    end
  endtask

  task automatic test_start_busy();
    int n_done, done_at, wr0;
    preload(32'hC000);
    wr0 = wr_count;
    n_done = 0;
    done_at = -1;
    start_copy(30, 60, 10);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 3) begin
        src_i = AWIDTH'(0);
        dst_i = AWIDTH'(80);
        len_i = (AWIDTH+1)'(5);
        start_i = 1'b1;
      end
      if (c == 4) start_i = 1'b0;
      if (done_o) begin
        n_done++;
        done_at = c;
      end
    end
    checks++;
    if (n_done != 1 || done_at != 12) begin
      errors++;
      $display("FAIL busy_done: pulses=%0d last_at=%0d expected 1 at 12", n_done, done_at);
    end
    checks++;
    if (wr_count - wr0 != 10) begin
      errors++;
      $display("FAIL busy_writes: got %0d expected 10", wr_count - wr0);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (mem[60 + k] !== DWIDTH'(32'hC000 + 30 + k)) begin
        errors++;
        $display("FAIL busy_mem[%0d]: got %h expected %h", 60 + k, mem[60 + k], 32'hC000 + 30 + k);
      end
    end
    checks++;
    if (mem[80] !== DWIDTH'(32'hC000 + 80)) begin
      errors++;
      $display("FAIL busy_untouched: mem[80]=%h expected %h", mem[80], 32'hC000 + 80);
    end
  endtask

  task automatic test_reset_mid();
    int wr0, done0;
    preload(32'hF000);
    wr0 = wr_count;
    start_copy(0, 40, 20);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ce0_o !== 1'b0 || ce1_o !== 1'b0 || run_o !== 1'b0 || idle_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: ce0/ce1/run/idle=%b%b%b%b expected 0001", ce0_o, ce1_o, run_o, idle_o);
    end
    done0 = done_count;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done_count != done0 || wr_count - wr0 != 4) begin
      errors++;
      $display("FAIL midreset_effects: done_pulses=%0d writes=%0d expected 0 4", done_count - done0, wr_count - wr0);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (mem[40 + k] !== DWIDTH'(32'hF000 + ((k < 4) ? k : 40 + k))) begin
        errors++;
        $display("FAIL midreset_mem[%0d]: got %h expected %h", 40 + k, mem[40 + k], 32'hF000 + ((k < 4) ? k : 40 + k));
      end
    end
    start_copy(0, 40, 20);
    repeat (23) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (mem[40 + k] !== DWIDTH'(32'hF000 + k)) begin
        errors++;
        $display("FAIL midreset_redo_mem[%0d]: got %h expected %h", 40 + k, mem[40 + k], 32'hF000 + k);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_done, first_done, second_done;
    preload(32'hE000);
    n_done = 0;
    first_done = -1;
    second_done = -1;
    @(negedge clk);
    src_i   = AWIDTH'(10);
    dst_i   = AWIDTH'(5);
    len_i   = (AWIDTH+1)'(10);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 3) begin
        src_i = AWIDTH'(60);
        dst_i = AWIDTH'(70);
      end
      if (c == 14) start_i = 1'b0;
      if (done_o) begin
        n_done++;
        if (first_done < 0) first_done = c;
        else second_done = c;
      end
    end
    checks++;
    if (n_done != 2 || first_done != 12 || second_done != 25) begin
      errors++;
      $display("FAIL b2b_done: pulses=%0d at %0d,%0d expected 2 at 12,25", n_done, first_done, second_done);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (mem[5 + k] !== DWIDTH'(32'hE000 + 10 + k) || mem[70 + k] !== DWIDTH'(32'hE000 + 60 + k)) begin
        errors++;
        $display("FAIL b2b_mem k=%0d: mem[%0d]=%h mem[%0d]=%h expected %h %h",
                 k, 5 + k, mem[5 + k], 70 + k, mem[70 + k], 32'hE000 + 10 + k, 32'hE000 + 60 + k);
      end
    end
  endtask

  task automatic test_len_clamp();
    int rd0, done_at;
    rd0 = rd_count;
    done_at = -1;
    start_copy(0, 0, 120);
    for (int c = 1; c <= 104; c++) begin
      @(negedge clk);
      if (done_o && done_at < 0) done_at = c;
    end
    checks++;
    if (rd_count - rd0 != MEM_SIZE || done_at != MEM_SIZE + 2) begin
      errors++;
      $display("FAIL clamp: reads=%0d done_at=%0d expected %0d %0d", rd_count - rd0, done_at, MEM_SIZE, MEM_SIZE + 2);
    end
  endtask

  task automatic test_address_range();
    checks++;
    if (bad_addr !== 1'b0) begin
      errors++;
      $display("FAIL addr_range: out-of-range address seen=%b expected 0", bad_addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_zero_length();
    test_wrap();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    test_len_clamp();
    test_address_range();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
